// File: rtl/counter_pkg.sv
// Shared types for the programmable up/down counter family: run-mode encoding
// and direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } cnt_mode_e;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/inf_counter.sv
// Signal bundle for connecting a programmable counter to its driving and
// monitoring environment.
interface inf_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic clk
);
    logic             rst;
    logic             load_n;
    logic [WIDTH-1:0] data_load;
    logic             ce;
    logic             up_down;
    cnt_mode_e        mode;
    logic [WIDTH-1:0] limit;
    logic             clr_flags;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             done;

    modport dut (
        input  clk, rst, load_n, data_load, ce, up_down, mode, limit, clr_flags,
        output count_out, max_count, zero, tc, ovf, unf, done
    );

    modport test (
        input  clk, count_out, max_count, zero, tc, ovf, unf, done,
        output rst, load_n, data_load, ce, up_down, mode, limit, clr_flags
    );

    modport monitor (
        input clk, rst, load_n, data_load, ce, up_down, mode, limit, clr_flags,
              count_out, max_count, zero, tc, ovf, unf, done
    );

endinterface

// File: rtl/prog_updown_counter.sv
// Load/up-down counter with programmable limit, wrap/saturate/one-shot modes,
// a registered terminal-count pulse and sticky overflow/underflow/done flags.
module prog_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_n,
    input  logic [WIDTH-1:0] data_load,
    input  logic             ce,
    input  logic             up_down,
    input  cnt_mode_e        mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             done
);

    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;
    logic             unf_next;
    logic             done_next;

    assign max_count = (count_out >= limit);
    assign zero      = (count_out == '0);

    // Flag clears are applied first so that any set event below overrides them.
    always_comb begin
        count_next = count_out;
        tc_next    = 1'b0;
        ovf_next   = ovf  & ~clr_flags;
        unf_next   = unf  & ~clr_flags;
        done_next  = done & ~clr_flags;

        if (!load_n) begin
            count_next = (data_load > limit) ? limit : data_load;
            done_next  = 1'b0;
        end else if (ce && !done) begin
            if (up_down == CNT_UP) begin
                if (count_out < limit) begin
                    count_next = count_out + WIDTH'(1);
                end else begin
                    tc_next = 1'b1;
                    case (mode)
                        MODE_SAT: begin
                            count_next = limit;
                            ovf_next   = 1'b1;
                        end
                        MODE_ONESHOT: begin
                            count_next = limit;
                            done_next  = 1'b1;
                        end
                        default: begin
                            count_next = '0;
                            ovf_next   = 1'b1;
                        end
                    endcase
                end
            end else begin
                if (count_out == '0) begin
                    tc_next = 1'b1;
                    case (mode)
                        MODE_SAT:     unf_next  = 1'b1;
                        MODE_ONESHOT: done_next = 1'b1;
                        default: begin
                            count_next = limit;
                            unf_next   = 1'b1;
                        end
                    endcase
                end else if (count_out > limit) begin
                    // A count stranded above a lowered limit snaps back into range.
                    count_next = limit;
                end else begin
                    count_next = count_out - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= WIDTH'(RESET_VALUE);
            tc        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            count_out <= count_next;
            tc        <= tc_next;
            ovf       <= ovf_next;
            unf       <= unf_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed and randomized bench for prog_updown_counter against an
// integer-arithmetic reference model.
module tb_prog_updown_counter;
    import counter_pkg::*;

    localparam int WIDTH = 4;
    localparam int RV    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_n;
    logic [WIDTH-1:0] data_load;
    logic             ce;
    logic             up_down;
    cnt_mode_e        mode;
    logic [WIDTH-1:0] limit;
    logic             clr_flags;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             done;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    bit m_tc = 0, m_ovf = 0, m_unf = 0, m_done = 0;

    prog_updown_counter #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .load_n(load_n), .data_load(data_load), .ce(ce),
        .up_down(up_down), .mode(mode), .limit(limit), .clr_flags(clr_flags),
        .count_out(count_out), .max_count(max_count), .zero(zero), .tc(tc),
        .ovf(ovf), .unf(unf), .done(done)
    );

    always #5 clk = ~clk;

    // Reference behaviour: the count lives in 0..lim and each rule is applied as plain arithmetic.
    task automatic modelEdge();
        int  lim;
        int  d;
        bit  was_done;
        lim      = int'(limit);
        d        = int'(data_load);
        was_done = m_done;
        m_tc     = 0;
        if (rst) begin
            m_count = RV;
            m_ovf = 0; m_unf = 0; m_done = 0;
        end else begin
            if (clr_flags) begin
                m_ovf = 0; m_unf = 0; m_done = 0;
            end
            if (!load_n) begin
                m_count = (d < lim) ? d : lim;
                m_done  = 0;
            end else if (ce && !was_done) begin
                if (up_down) begin
                    if (m_count < lim) m_count = m_count + 1;
                    else begin
                        m_tc = 1;
                        if (mode == MODE_SAT) begin m_count = lim; m_ovf = 1; end
                        else if (mode == MODE_ONESHOT) begin m_count = lim; m_done = 1; end
                        else begin m_count = (m_count + 1) % (lim + 1) == 0 ? 0 : 0; m_ovf = 1; end
                    end
                end else begin
                    if (m_count == 0) begin
                        m_tc = 1;
                        if (mode == MODE_SAT) m_unf = 1;
                        else if (mode == MODE_ONESHOT) m_done = 1;
                        else begin m_count = lim; m_unf = 1; end
                    end else if (m_count > lim) m_count = lim;
                    else m_count = m_count - 1;
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
            $error("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".count"}, 32'(count_out), 32'(m_count));
        checkValue({tag, ".tc"},    32'(tc),        32'(m_tc));
        checkValue({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
        checkValue({tag, ".unf"},   32'(unf),       32'(m_unf));
        checkValue({tag, ".done"},  32'(done),      32'(m_done));
        checkValue({tag, ".max"},   32'(max_count), 32'(m_count >= int'(limit)));
        checkValue({tag, ".zero"},  32'(zero),      32'(m_count == 0));
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge, then compare.
    task automatic applyStimulus(input string tag, input logic r, input logic ld_n,
                                 input logic [WIDTH-1:0] d, input logic c, input logic ud,
                                 input cnt_mode_e m, input logic [WIDTH-1:0] lim,
                                 input logic clr);
        rst = r; load_n = ld_n; data_load = d; ce = c; up_down = ud;
        mode = m; limit = lim; clr_flags = clr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b1; load_n = 1'b1; data_load = '0; ce = 1'b0; up_down = CNT_UP;
        mode = MODE_WRAP; limit = 4'd9; clr_flags = 1'b0;

        // Reset wins over simultaneous load and count.
        applyStimulus("rst0", 1'b1, 1'b0, 4'd7, 1'b1, CNT_UP, MODE_WRAP, 4'd9, 1'b0);
        applyStimulus("rst1", 1'b1, 1'b0, 4'd7, 1'b1, CNT_UP, MODE_WRAP, 4'd9, 1'b0);
        checkValue("rst.const", 32'(count_out), 32'd3);

        // WRAP up through limit 9.
        applyStimulus("wrap.ld", 1'b0, 1'b0, 4'd0, 1'b0, CNT_UP, MODE_WRAP, 4'd9, 1'b0);
        for (int i = 0; i < 12; i++)
            applyStimulus("wrap.up", 1'b0, 1'b1, 4'd0, 1'b1, CNT_UP, MODE_WRAP, 4'd9, 1'b0);
        checkValue("wrap.const", 32'(count_out), 32'd2);
        checkValue("wrap.ovf", 32'(ovf), 32'd1);

        // SAT down from 2, then clear the flags with counting disabled.
        applyStimulus("sat.ld", 1'b0, 1'b0, 4'd2, 1'b0, CNT_DOWN, MODE_SAT, 4'd9, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus("sat.dn", 1'b0, 1'b1, 4'd0, 1'b1, CNT_DOWN, MODE_SAT, 4'd9, 1'b0);
        checkValue("sat.tc", 32'(tc), 32'd1);
        applyStimulus("sat.clr", 1'b0, 1'b1, 4'd0, 1'b0, CNT_DOWN, MODE_SAT, 4'd9, 1'b1);
        checkValue("sat.unf", 32'(unf), 32'd0);

        // ONESHOT up to limit 5, halt, then restart by load.
        applyStimulus("os.ld", 1'b0, 1'b0, 4'd0, 1'b0, CNT_UP, MODE_ONESHOT, 4'd5, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus("os.up", 1'b0, 1'b1, 4'd0, 1'b1, CNT_UP, MODE_ONESHOT, 4'd5, 1'b0);
        checkValue("os.done", 32'(done), 32'd1);
        checkValue("os.hold", 32'(count_out), 32'd5);
        applyStimulus("os.ld2", 1'b0, 1'b0, 4'd2, 1'b1, CNT_UP, MODE_ONESHOT, 4'd5, 1'b0);
        checkValue("os.reload", 32'(count_out), 32'd2);

        // Load is clamped to the limit; reset then overrides load and ce.
        applyStimulus("clamp", 1'b0, 1'b0, 4'd12, 1'b0, CNT_UP, MODE_WRAP, 4'd7, 1'b0);
        checkValue("clamp.const", 32'(count_out), 32'd7);
        applyStimulus("rst2", 1'b1, 1'b0, 4'd12, 1'b1, CNT_UP, MODE_WRAP, 4'd7, 1'b0);

        // Lowered limit: up wraps, down snaps to the limit, set beats clear.
        applyStimulus("low.ld", 1'b0, 1'b0, 4'd8, 1'b0, CNT_UP, MODE_WRAP, 4'd15, 1'b0);
        applyStimulus("low.up", 1'b0, 1'b1, 4'd0, 1'b1, CNT_UP, MODE_WRAP, 4'd3, 1'b0);
        checkValue("low.tc", 32'(tc), 32'd1);
        applyStimulus("low.ld8", 1'b0, 1'b0, 4'd8, 1'b0, CNT_UP, MODE_WRAP, 4'd15, 1'b0);
        applyStimulus("low.dn", 1'b0, 1'b1, 4'd0, 1'b1, CNT_DOWN, MODE_WRAP, 4'd3, 1'b0);
        checkValue("low.snap", 32'(count_out), 32'd3);
        applyStimulus("low.clr", 1'b0, 1'b1, 4'd0, 1'b0, CNT_UP, MODE_WRAP, 4'd3, 1'b1);
        applyStimulus("low.setwin", 1'b0, 1'b1, 4'd0, 1'b1, CNT_UP, MODE_WRAP, 4'd3, 1'b1);
        checkValue("low.ovf", 32'(ovf), 32'd1);

        // limit=0: every step is terminal.
        applyStimulus("z.ld", 1'b0, 1'b0, 4'd4, 1'b0, CNT_UP, MODE_WRAP, 4'd0, 1'b1);
        applyStimulus("z.up", 1'b0, 1'b1, 4'd0, 1'b1, CNT_UP, MODE_WRAP, 4'd0, 1'b0);
        applyStimulus("z.dn", 1'b0, 1'b1, 4'd0, 1'b1, CNT_DOWN, MODE_RSVD, 4'd0, 1'b0);
        checkValue("z.unf", 32'(unf), 32'd1);

        // Randomized traffic with occasional limit changes.
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] lim_r;
            lim_r = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : limit;
            applyStimulus("rnd",
                          ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 7) != 0),
                          WIDTH'($urandom),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom),
                          cnt_mode_e'($urandom_range(0, 3)),
                          lim_r,
                          ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
